// File: rtl/lsu_dram_ctrl_pkg.sv
// Shared types and lane helpers for the load/store DRAM controller.
package lsu_pkg;

   localparam int LSU_XLEN = 32;

   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_funct3_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD1  = 2'd1,
      RD2  = 2'd2,
      ST2  = 2'd3
   } lsu_state_e;

   // A zero mask doubles as the illegal-funct3 indicator.
   function automatic logic [3:0] sizeMask(input logic [2:0] funct3);
      case (funct3)
         LSU_B, LSU_BU: sizeMask = 4'b0001;
         LSU_H, LSU_HU: sizeMask = 4'b0011;
         LSU_W:         sizeMask = 4'b1111;
         default:       sizeMask = 4'b0000;
      endcase
   endfunction

   function automatic logic [LSU_XLEN-1:0] extendLoad(input logic [LSU_XLEN-1:0] data,
                                                      input logic [2:0] funct3);
      case (funct3)
         LSU_B:   extendLoad = {{24{data[7]}}, data[7:0]};
         LSU_H:   extendLoad = {{16{data[15]}}, data[15:0]};
         LSU_BU:  extendLoad = {24'h000000, data[7:0]};
         LSU_HU:  extendLoad = {16'h0000, data[15:0]};
         default: extendLoad = data;
      endcase
   endfunction

endpackage

// File: rtl/lsu_dram_ctrl_if.sv
// Request/response and DRAM port bundle of the load/store controller.
interface lsu_dram_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int XLEN   = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              rsp_valid;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] dram_a;
   logic [3:0]        dram_we;
   logic [XLEN-1:0]   dram_din;
   logic [XLEN-1:0]   dram_spo;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, dram_spo,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, dram_a, dram_we, dram_din
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, dram_spo,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, dram_a, dram_we, dram_din
   );
endinterface

// File: rtl/lsu_dram_ctrl_load_align.sv
// Merges {hi, lo} DRAM words, shifts the addressed bytes down and extends them.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [LSU_XLEN-1:0] i_lo,
   input  logic [LSU_XLEN-1:0] i_hi,
   input  logic [1:0]          i_off,
   input  logic [2:0]          i_funct3,
   output logic [LSU_XLEN-1:0] o_data
);

   logic [LSU_XLEN-1:0] w_shifted;

   assign w_shifted = LSU_XLEN'({i_hi, i_lo} >> {i_off, 3'b000});
   assign o_data    = extendLoad(w_shifted, i_funct3);

endmodule

// File: rtl/lsu_dram_ctrl.sv
// Load/store controller for a one-cycle-latency byte-enable DRAM.
// Word-crossing accesses are split in two only when MISALIGN_SPLIT_EN is defined.
module lsu_dram_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int XLEN   = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   lsu_dram_ctrl_if.slave  bus
);

   lsu_state_e        r_state, w_next;
   logic [ADDR_W-1:0] r_addr, w_reqWord, w_addrNext, w_dramA;
   logic [1:0]        r_off, w_off;
   logic [2:0]        r_funct3;
   logic [3:0]        w_mask, w_we;
   logic [7:0]        w_m8;
   logic [XLEN-1:0]   w_dLo, w_loLane, w_loadData, w_dramDin;
   logic              w_split, w_err, w_accept;
   logic              r_rspValid, r_rspErr;
   logic [XLEN-1:0]   r_rspRdata;
`ifdef MISALIGN_SPLIT_EN
   logic              r_split;
   logic [3:0]        r_weHi;
   logic [XLEN-1:0]   r_dHi, r_word0;
   logic [2*XLEN-1:0] w_d64;
`endif

   assign w_reqWord  = bus.req_addr[ADDR_W+1:2];
   assign w_off      = bus.req_addr[1:0];
   assign w_mask     = sizeMask(bus.req_funct3);
   assign w_m8       = {4'b0000, w_mask} << w_off;
   assign w_split    = |w_m8[7:4];
   assign w_accept   = bus.req_valid && (r_state == IDLE);
   assign w_addrNext = r_addr + ADDR_W'(1);

`ifdef MISALIGN_SPLIT_EN
   assign w_d64   = {{XLEN{1'b0}}, bus.req_wdata} << {w_off, 3'b000};
   assign w_dLo   = w_d64[XLEN-1:0];
   assign w_err   = ~|w_mask;
   assign w_loLane = (r_state == RD2) ? r_word0 : bus.dram_spo;
`else
   assign w_dLo   = bus.req_wdata << {w_off, 3'b000};
   assign w_err   = (~|w_mask) | w_split;
   assign w_loLane = bus.dram_spo;
`endif

   lsu_load_align u_align (
      .i_lo     (w_loLane),
      .i_hi     (bus.dram_spo),
      .i_off    (r_off),
      .i_funct3 (r_funct3),
      .o_data   (w_loadData)
   );

   always_comb begin
      w_next    = r_state;
      w_dramA   = w_reqWord;
      w_we      = 4'b0000;
      w_dramDin = w_dLo;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_err) begin
               if (bus.req_we) begin
                  w_we = w_m8[3:0];
`ifdef MISALIGN_SPLIT_EN
                  if (w_split) w_next = ST2;
`endif
               end else begin
                  w_next = RD1;
               end
            end
         end
         RD1: begin
            w_dramA = r_addr;
            w_next  = IDLE;
`ifdef MISALIGN_SPLIT_EN
            if (r_split) begin
               w_dramA = w_addrNext;
               w_next  = RD2;
            end
`endif
         end
`ifdef MISALIGN_SPLIT_EN
         RD2: begin
            w_dramA = w_addrNext;
            w_next  = IDLE;
         end
         ST2: begin
            w_dramA   = w_addrNext;
            w_we      = r_weHi;
            w_dramDin = r_dHi;
            w_next    = IDLE;
         end
`endif
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_off      <= '0;
         r_funct3   <= '0;
         r_rspValid <= 1'b0;
         r_rspErr   <= 1'b0;
         r_rspRdata <= '0;
`ifdef MISALIGN_SPLIT_EN
         r_split    <= 1'b0;
         r_weHi     <= '0;
         r_dHi      <= '0;
         r_word0    <= '0;
`endif
      end else begin
         r_state    <= w_next;
         r_rspValid <= 1'b0;
         r_rspErr   <= 1'b0;
         r_rspRdata <= '0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr   <= w_reqWord;
                  r_off    <= w_off;
                  r_funct3 <= bus.req_funct3;
`ifdef MISALIGN_SPLIT_EN
                  r_split  <= w_split;
                  r_weHi   <= w_m8[7:4];
                  r_dHi    <= w_d64[2*XLEN-1:XLEN];
`endif
                  if (w_err) begin
                     r_rspValid <= 1'b1;
                     r_rspErr   <= 1'b1;
                  end else if (bus.req_we && !w_split) begin
                     r_rspValid <= 1'b1;
                  end
               end
            end
            RD1: begin
`ifdef MISALIGN_SPLIT_EN
               if (r_split) begin
                  r_word0 <= bus.dram_spo;
               end else begin
                  r_rspValid <= 1'b1;
                  r_rspRdata <= w_loadData;
               end
`else
               r_rspValid <= 1'b1;
               r_rspRdata <= w_loadData;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            RD2: begin
               r_rspValid <= 1'b1;
               r_rspRdata <= w_loadData;
            end
            ST2: r_rspValid <= 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // Write enables are gated by reset so an interrupted split store never completes.
   assign bus.req_ready = (r_state == IDLE);
   assign bus.dram_a    = w_dramA;
   assign bus.dram_we   = rst_n ? w_we : 4'b0000;
   assign bus.dram_din  = w_dramDin;
   assign bus.rsp_valid = r_rspValid;
   assign bus.rsp_rdata = r_rspRdata;
   assign bus.rsp_err   = r_rspErr;

endmodule

// File: tb/tb_lsu_dram_ctrl.sv
// Directed testbench for lsu_dram_ctrl with a behavioural synchronous-read DRAM.
module tb_lsu_dram_ctrl;

   logic        clk;
   logic        rst_n;
   int          checks;
   int          errors;
   logic [31:0] mem [0:65535];

   lsu_dram_ctrl_if #(.ADDR_W(16), .XLEN(32)) bus ();

   lsu_dram_ctrl #(.ADDR_W(16), .XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-enable write and registered read, both on the rising edge.
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (bus.dram_we[k]) mem[bus.dram_a][8*k +: 8] <= bus.dram_din[8*k +: 8];
      end
      bus.dram_spo <= mem[bus.dram_a];
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic valid, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid  = valid;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      #1;
   endtask

   task automatic idle;
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Aligned (non-crossing) load: response two cycles after acceptance.
   task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] expected);
      applyStimulus(1'b1, 1'b0, f3, addr, 32'h0);
      tick;
      idle;
      checkOutput({tag, "_busy"}, {31'b0, bus.req_ready}, 32'h0);
      tick;
      checkOutput({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput({tag, "_data"}, bus.rsp_rdata, expected);
   endtask

   logic [31:0] preAddr [5];
   logic [31:0] preData [5];

   initial begin
      checks = 0;
      errors = 0;
      preAddr = '{32'h10, 32'h20, 32'h24, 32'h0, 32'h3FFFC};
      preData = '{32'h8899AABB, 32'h44332211, 32'h88776655, 32'h11111111, 32'h22222222};
      rst_n = 1'b0;
      bus.dram_spo = 32'h0;
      applyStimulus(1'b1, 1'b1, 3'b010, 32'h0, 32'h0);
      repeat (2) @(negedge clk);

      checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
      checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      checkOutput("rst_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
      checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
      checkOutput("rst_dram_we", {28'b0, bus.dram_we}, 32'h0);
      idle;
      rst_n = 1'b1;
      tick;

      $display("[TB] back-to-back aligned stores");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 3'b010, preAddr[i], preData[i]);
         checkOutput("b2b_we", {28'b0, bus.dram_we}, 32'hF);
         tick;
         checkOutput("b2b_ack", {31'b0, bus.rsp_valid}, 32'h1);
      end
      idle;
      checkOutput("b2b_mem16", mem[16'h0008], 32'h44332211);

      $display("[TB] byte/half loads");
      applyStimulus(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
      checkOutput("lb_dram_a", {16'b0, bus.dram_a}, 32'h4);
      checkOutput("lb_no_we", {28'b0, bus.dram_we}, 32'h0);
      tick;
      idle;
      checkOutput("lb_t1_valid", {31'b0, bus.rsp_valid}, 32'h0);
      tick;
      checkOutput("lb_valid", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("lb_data", bus.rsp_rdata, 32'hFFFFFF88);
      doLoad("lbu", 3'b100, 32'h13, 32'h00000088);
      doLoad("lh_off1", 3'b001, 32'h11, 32'hFFFF99AA);
      doLoad("lhu_off2", 3'b101, 32'h12, 32'h00008899);

      $display("[TB] word-crossing load");
`ifdef MISALIGN_SPLIT_EN
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h21, 32'h0);
      tick;
      idle;
      checkOutput("lwx_t1_ready", {31'b0, bus.req_ready}, 32'h0);
      checkOutput("lwx_t1_addr", {16'b0, bus.dram_a}, 32'h9);
      tick;
      checkOutput("lwx_t2_ready", {31'b0, bus.req_ready}, 32'h0);
      checkOutput("lwx_t2_valid", {31'b0, bus.rsp_valid}, 32'h0);
      tick;
      checkOutput("lwx_valid", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("lwx_data", bus.rsp_rdata, 32'h55443322);
`else
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h21, 32'h0);
      tick;
      idle;
      checkOutput("lwx_valid", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("lwx_err", {31'b0, bus.rsp_err}, 32'h1);
      checkOutput("lwx_ready", {31'b0, bus.req_ready}, 32'h1);
      tick;
      checkOutput("lwx_no_second", {31'b0, bus.rsp_valid}, 32'h0);
`endif

      $display("[TB] halfword store");
      applyStimulus(1'b1, 1'b1, 3'b001, 32'h22, 32'h00001234);
      checkOutput("sh_we", {28'b0, bus.dram_we}, 32'hC);
      checkOutput("sh_din", bus.dram_din, 32'h12340000);
      checkOutput("sh_addr", {16'b0, bus.dram_a}, 32'h8);
      tick;
      idle;
      checkOutput("sh_ack", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("sh_err", {31'b0, bus.rsp_err}, 32'h0);
      doLoad("lw_after_sh", 3'b010, 32'h20, 32'h12342211);

      $display("[TB] wrapping word store");
      applyStimulus(1'b1, 1'b1, 3'b010, 32'h3FFFF, 32'hDEADBEEF);
`ifdef MISALIGN_SPLIT_EN
      checkOutput("swx_lo_addr", {16'b0, bus.dram_a}, 32'hFFFF);
      checkOutput("swx_lo_we", {28'b0, bus.dram_we}, 32'h8);
      checkOutput("swx_lo_din", bus.dram_din, 32'hEF000000);
      tick;
      idle;
      checkOutput("swx_hi_addr", {16'b0, bus.dram_a}, 32'h0);
      checkOutput("swx_hi_we", {28'b0, bus.dram_we}, 32'h7);
      checkOutput("swx_hi_din", bus.dram_din, 32'h00DEADBE);
      checkOutput("swx_t1_valid", {31'b0, bus.rsp_valid}, 32'h0);
      tick;
      checkOutput("swx_ack", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("swx_mem_ffff", mem[16'hFFFF], 32'hEF222222);
      checkOutput("swx_mem_0", mem[16'h0000], 32'h11DEADBE);

      $display("[TB] reset during second store half");
      applyStimulus(1'b1, 1'b1, 3'b010, 32'h3FFFF, 32'hCAFEBABE);
      tick;
      idle;
      rst_n = 1'b0;
      #1;
      checkOutput("st2rst_we", {28'b0, bus.dram_we}, 32'h0);
      checkOutput("st2rst_valid", {31'b0, bus.rsp_valid}, 32'h0);
      tick;
      rst_n = 1'b1;
      checkOutput("st2rst_mem_0", mem[16'h0000], 32'h11DEADBE);
      checkOutput("st2rst_mem_ffff", mem[16'hFFFF], 32'hBE222222);
      tick;
      checkOutput("st2rst_ready", {31'b0, bus.req_ready}, 32'h1);
      checkOutput("st2rst_no_rsp", {31'b0, bus.rsp_valid}, 32'h0);
`else
      checkOutput("swx_no_we", {28'b0, bus.dram_we}, 32'h0);
      tick;
      idle;
      checkOutput("swx_valid", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("swx_err", {31'b0, bus.rsp_err}, 32'h1);
      checkOutput("swx_mem_ffff", mem[16'hFFFF], 32'h22222222);
      checkOutput("swx_mem_0", mem[16'h0000], 32'h11111111);
`endif

      $display("[TB] reset during a load");
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      tick;
      idle;
      rst_n = 1'b0;
      #1;
      checkOutput("ldrst_ready", {31'b0, bus.req_ready}, 32'h1);
      tick;
      rst_n = 1'b1;
      checkOutput("ldrst_no_rsp", {31'b0, bus.rsp_valid}, 32'h0);
      tick;

      $display("[TB] illegal funct3");
      applyStimulus(1'b1, 1'b1, 3'b011, 32'h10, 32'h0);
      checkOutput("ill_st_we", {28'b0, bus.dram_we}, 32'h0);
      tick;
      idle;
      checkOutput("ill_st_valid", {31'b0, bus.rsp_valid}, 32'h1);
      checkOutput("ill_st_err", {31'b0, bus.rsp_err}, 32'h1);
      checkOutput("ill_st_mem", mem[16'h0004], 32'h8899AABB);
      applyStimulus(1'b1, 1'b0, 3'b110, 32'h10, 32'h0);
      tick;
      idle;
      checkOutput("ill_ld_err", {31'b0, bus.rsp_err}, 32'h1);
      checkOutput("ill_ld_rdata", bus.rsp_rdata, 32'h0);
      checkOutput("ill_ld_ready", {31'b0, bus.req_ready}, 32'h1);
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
